// File: rtl/banked_regfile_if.sv
// Bus bundle for banked_regfile: read ports, GPR/PC/CPSR/SPSR writes and exception control.
interface banked_regfile_if #(
  parameter int DATA_W = 32,
  parameter int NUM_RD = 3
);
  logic                     rd_en;
  logic [NUM_RD*4-1:0]      rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [3:0]               wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     pc_wr_en;
  logic [DATA_W-1:0]        pc_wr_data;
  logic                     pc_inc;
  logic [DATA_W-1:0]        pc;
  logic                     cpsr_wr_en;
  logic [DATA_W-1:0]        cpsr_wr_data;
  logic [DATA_W-1:0]        cpsr_wr_mask;
  logic                     spsr_wr_en;
  logic                     exc_req;
  logic [4:0]               exc_mode;
  logic [DATA_W-1:0]        exc_vector;
  logic                     exc_ret;
  logic [DATA_W-1:0]        cpsr;
  logic [DATA_W-1:0]        spsr;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, pc_wr_en, pc_wr_data, pc_inc,
           cpsr_wr_en, cpsr_wr_data, cpsr_wr_mask, spsr_wr_en,
           exc_req, exc_mode, exc_vector, exc_ret,
    input  rd_data, pc, cpsr, spsr
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, pc_wr_en, pc_wr_data, pc_inc,
           cpsr_wr_en, cpsr_wr_data, cpsr_wr_mask, spsr_wr_en,
           exc_req, exc_mode, exc_vector, exc_ret,
    output rd_data, pc, cpsr, spsr
  );
endinterface

// File: rtl/banked_regfile.sv
// ARM-style banked register file: mode-mapped GPRs, PC, CPSR, SPSRs, one-edge exception entry/return.
// Optional BANKED_FIQ_EN gives fiq its own r8-r12; otherwise r8-r12 are shared by all modes.
module banked_regfile #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_RD   = 3,
  parameter int                PC_STEP  = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  banked_regfile_if.slave bus
);

  typedef enum logic [2:0] {M_USR, M_FIQ, M_IRQ, M_SVC, M_ABT, M_UND} mode_t;

`ifdef BANKED_FIQ_EN
  localparam int FIQ_HI = 5;
`else
  localparam int FIQ_HI = 0;
`endif
  // Layout: r0-r7 | r8-r12 | fiq r8-r12 (optional) | r13/r14 pairs per mode
  localparam int BANK_BASE = 13 + FIQ_HI;
  localparam int NUM_PHYS  = BANK_BASE + 12;
  localparam int IDX_W     = $clog2(NUM_PHYS);

  function automatic mode_t decode_mode(input logic [4:0] m);
    case (m)
      5'b10001: return M_FIQ;
      5'b10010: return M_IRQ;
      5'b10011: return M_SVC;
      5'b10111: return M_ABT;
      5'b11011: return M_UND;
      default:  return M_USR;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] phys_idx(input mode_t m, input logic [3:0] a);
    int i;
    i = 0;
    if (a < 4'd8) begin
      i = int'(a);
    end else if (a < 4'd13) begin
      i = int'(a);
`ifdef BANKED_FIQ_EN
      if (m == M_FIQ) i = int'(a) + 5;
`endif
    end else if (a < 4'd15) begin
      i = BANK_BASE + 2 * int'(m) + int'(a) - 13;
    end
    return IDX_W'(i);
  endfunction

  logic [DATA_W-1:0]        gpr [NUM_PHYS];
  logic [DATA_W-1:0]        spsr_bank [6];
  logic [DATA_W-1:0]        pc_q;
  logic [DATA_W-1:0]        cpsr_q;
  logic [NUM_RD*DATA_W-1:0] rd_q;
  logic [NUM_RD*DATA_W-1:0] rd_nxt;
  logic [DATA_W-1:0]        exc_cpsr;

  mode_t            cur_mode;
  mode_t            exc_m;
  logic             exc_go;
  logic             ret_go;
  logic             gpr_we;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] lr_idx;

  assign cur_mode = decode_mode(cpsr_q[4:0]);
  assign exc_m    = decode_mode(bus.exc_mode);
  assign exc_go   = bus.exc_req && (exc_m != M_USR);
  assign ret_go   = bus.exc_ret && (cur_mode != M_USR);
  assign gpr_we   = bus.wr_en && (bus.wr_addr != 4'hF);
  assign wr_idx   = phys_idx(cur_mode, bus.wr_addr);
  assign lr_idx   = phys_idx(exc_m, 4'd14);

  always_comb begin
    exc_cpsr      = cpsr_q;
    exc_cpsr[4:0] = bus.exc_mode;
    exc_cpsr[7]   = 1'b1;
    exc_cpsr[5]   = 1'b0;
    if (exc_m == M_FIQ) exc_cpsr[6] = 1'b1;
  end

  // Write-first bypass covers only the GPR write port, not the exception LR save
  always_comb begin
    rd_nxt = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (bus.rd_addr[4*k +: 4] == 4'hF)
        rd_nxt[k*DATA_W +: DATA_W] = pc_q;
      else if (gpr_we && (wr_idx == phys_idx(cur_mode, bus.rd_addr[4*k +: 4])))
        rd_nxt[k*DATA_W +: DATA_W] = bus.wr_data;
      else
        rd_nxt[k*DATA_W +: DATA_W] = gpr[phys_idx(cur_mode, bus.rd_addr[4*k +: 4])];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PHYS; i++) gpr[i] <= '0;
      for (int i = 0; i < 6; i++) spsr_bank[i] <= '0;
      pc_q   <= RESET_PC;
      cpsr_q <= DATA_W'(32'hD3);
      rd_q   <= '0;
    end else begin
      if (bus.rd_en) rd_q <= rd_nxt;
      if (gpr_we) gpr[wr_idx] <= bus.wr_data;

      // LR save is issued after the GPR write so it wins if both hit one register
      if (exc_go) begin
        spsr_bank[exc_m] <= cpsr_q;
        gpr[lr_idx]      <= pc_q;
        cpsr_q           <= exc_cpsr;
      end else if (ret_go) begin
        cpsr_q <= spsr_bank[cur_mode];
      end else begin
        if (bus.cpsr_wr_en)
          cpsr_q <= (cpsr_q & ~bus.cpsr_wr_mask) | (bus.cpsr_wr_data & bus.cpsr_wr_mask);
        if (bus.spsr_wr_en && (cur_mode != M_USR))
          spsr_bank[cur_mode] <= bus.cpsr_wr_data;
      end

      if (exc_go)
        pc_q <= bus.exc_vector;
      else if (bus.pc_wr_en)
        pc_q <= bus.pc_wr_data;
      else if (bus.wr_en && (bus.wr_addr == 4'hF))
        pc_q <= bus.wr_data;
      else if (bus.pc_inc)
        pc_q <= pc_q + DATA_W'(PC_STEP);
    end
  end

  assign bus.rd_data = rd_q;
  assign bus.pc      = pc_q;
  assign bus.cpsr    = cpsr_q;
  assign bus.spsr    = (cur_mode == M_USR) ? '0 : spsr_bank[cur_mode];

endmodule

// File: tb/tb_banked_regfile.sv
// Testbench for banked_regfile: directed vector table, reset-during-exception sequence,
// and random traffic checked against a name-keyed reference model.
module tb_banked_regfile;
  localparam int          DW   = 32;
  localparam int          NR   = 3;
  localparam int          STEP = 4;
  localparam logic [31:0] RPC  = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  banked_regfile_if #(.DATA_W(DW), .NUM_RD(NR)) bus ();

  banked_regfile #(.DATA_W(DW), .NUM_RD(NR), .PC_STEP(STEP), .RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string name, logic [95:0] act, logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: registers named by architectural view, e.g. "r13_irq", "r8_fiq", "r3"
  logic [31:0] m_reg  [string];
  logic [31:0] m_spsr [string];
  logic [31:0] m_pc, m_cpsr;
  logic [95:0] m_rd;

  function automatic string mode_name(logic [4:0] m);
    case (m)
      5'b10001: return "fiq";
      5'b10010: return "irq";
      5'b10011: return "svc";
      5'b10111: return "abt";
      5'b11011: return "und";
      default:  return "usr";
    endcase
  endfunction

  function automatic string reg_name(string md, int r);
    if (r < 8) return $sformatf("r%0d", r);
    if (r < 13) begin
`ifdef BANKED_FIQ_EN
      if (md == "fiq") return $sformatf("r%0d_fiq", r);
`endif
      return $sformatf("r%0d", r);
    end
    return $sformatf("r%0d_%s", r, md);
  endfunction

  function automatic logic [31:0] rget(string k);
    return m_reg.exists(k) ? m_reg[k] : 32'h0;
  endfunction

  function automatic logic [31:0] sget(string k);
    return m_spsr.exists(k) ? m_spsr[k] : 32'h0;
  endfunction

  function automatic logic [31:0] exp_spsr();
    string md = mode_name(m_cpsr[4:0]);
    return (md == "usr") ? 32'h0 : sget(md);
  endfunction

  task automatic model_reset();
    m_reg.delete();
    m_spsr.delete();
    m_pc   = RPC;
    m_cpsr = 32'hD3;
    m_rd   = '0;
  endtask

  task automatic model_step();
    string md = mode_name(m_cpsr[4:0]);
    string em = mode_name(bus.exc_mode);
    logic [31:0] pc0 = m_pc;
    logic [31:0] cpsr0 = m_cpsr;
    logic [31:0] c;
    if (bus.rd_en) begin
      for (int k = 0; k < NR; k++) begin
        int a;
        a = int'(bus.rd_addr[4*k +: 4]);
        if (a == 15)
          m_rd[32*k +: 32] = pc0;
        else if (bus.wr_en && bus.wr_addr != 4'hF && reg_name(md, int'(bus.wr_addr)) == reg_name(md, a))
          m_rd[32*k +: 32] = bus.wr_data;
        else
          m_rd[32*k +: 32] = rget(reg_name(md, a));
      end
    end
    if (bus.wr_en && bus.wr_addr != 4'hF) m_reg[reg_name(md, int'(bus.wr_addr))] = bus.wr_data;
    if (bus.exc_req && em != "usr") begin
      m_spsr[em] = cpsr0;
      m_reg[reg_name(em, 14)] = pc0;
      c = cpsr0;
      c[4:0] = bus.exc_mode;
      c[7] = 1'b1;
      c[5] = 1'b0;
      if (em == "fiq") c[6] = 1'b1;
      m_cpsr = c;
      m_pc = bus.exc_vector;
    end else begin
      if (bus.exc_ret && md != "usr") begin
        m_cpsr = sget(md);
      end else begin
        if (bus.cpsr_wr_en)
          m_cpsr = (cpsr0 & ~bus.cpsr_wr_mask) | (bus.cpsr_wr_data & bus.cpsr_wr_mask);
        if (bus.spsr_wr_en && md != "usr") m_spsr[md] = bus.cpsr_wr_data;
      end
      if (bus.pc_wr_en) m_pc = bus.pc_wr_data;
      else if (bus.wr_en && bus.wr_addr == 4'hF) m_pc = bus.wr_data;
      else if (bus.pc_inc) m_pc = pc0 + STEP;
    end
  endtask

  task automatic idle();
    bus.rd_en = 0; bus.rd_addr = '0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.pc_wr_en = 0; bus.pc_wr_data = '0; bus.pc_inc = 0;
    bus.cpsr_wr_en = 0; bus.cpsr_wr_data = '0; bus.cpsr_wr_mask = '0; bus.spsr_wr_en = 0;
    bus.exc_req = 0; bus.exc_mode = '0; bus.exc_vector = '0; bus.exc_ret = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic wr_en; logic [3:0] wr_addr; logic [31:0] wr_data;
    logic rd_en; logic [11:0] rd_addr;
    logic cw_en; logic [31:0] cw_data; logic [31:0] cw_mask;
    logic pw_en; logic [31:0] pw_data; logic pc_inc;
    logic exc_req; logic [4:0] exc_mode; logic [31:0] exc_vec; logic exc_ret;
    logic chk_rd; logic [95:0] e_rd; logic [31:0] e_pc; logic [31:0] e_cpsr; logic [31:0] e_spsr;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t nop(logic [31:0] pc, logic [31:0] cpsr, logic [31:0] spsr);
    vec_t v;
    v = '{default: 0};
    v.e_pc = pc; v.e_cpsr = cpsr; v.e_spsr = spsr;
    return v;
  endfunction

  task automatic apply(vec_t v, int i);
    bus.wr_en = v.wr_en; bus.wr_addr = v.wr_addr; bus.wr_data = v.wr_data;
    bus.rd_en = v.rd_en; bus.rd_addr = v.rd_addr;
    bus.cpsr_wr_en = v.cw_en; bus.cpsr_wr_data = v.cw_data; bus.cpsr_wr_mask = v.cw_mask;
    bus.pc_wr_en = v.pw_en; bus.pc_wr_data = v.pw_data; bus.pc_inc = v.pc_inc;
    bus.exc_req = v.exc_req; bus.exc_mode = v.exc_mode; bus.exc_vector = v.exc_vec;
    bus.exc_ret = v.exc_ret; bus.spsr_wr_en = 0;
    step();
    if (v.chk_rd) check($sformatf("v%0d rd_data", i), bus.rd_data, v.e_rd);
    check($sformatf("v%0d pc", i), bus.pc, v.e_pc);
    check($sformatf("v%0d cpsr", i), bus.cpsr, v.e_cpsr);
    check($sformatf("v%0d spsr", i), bus.spsr, v.e_spsr);
    idle();
  endtask

  logic [4:0] modes [8] = '{5'b10000, 5'b10001, 5'b10010, 5'b10011,
                            5'b10111, 5'b11011, 5'b11111, 5'b00101};

  initial begin
    vec_t v;
    logic [31:0] r;
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset pc", bus.pc, RPC);
    check("reset cpsr", bus.cpsr, 32'hD3);
    check("reset spsr", bus.spsr, 32'h0);
    check("reset rd_data", bus.rd_data, 96'h0);

    v = nop(0, 32'hD3, 0); v.rd_en = 1; v.rd_addr = {4'd15, 4'd13, 4'd0};
    v.chk_rd = 1; v.e_rd = {32'h0, 32'h0, 32'h0}; tv.push_back(v);
    v = nop(0, 32'hD3, 0); v.wr_en = 1; v.wr_addr = 13; v.wr_data = 32'hAAAA0000; tv.push_back(v);
    v = nop(0, 32'hD0, 0); v.cw_en = 1; v.cw_data = 32'h10; v.cw_mask = 32'h1F; tv.push_back(v);
    v = nop(0, 32'hD0, 0); v.wr_en = 1; v.wr_addr = 13; v.wr_data = 32'h5555; tv.push_back(v);
    v = nop(0, 32'hD0, 0); v.rd_en = 1; v.rd_addr = {4'd0, 4'd0, 4'd13};
    v.chk_rd = 1; v.e_rd = {32'h0, 32'h0, 32'h5555}; tv.push_back(v);
    v = nop(0, 32'hD3, 0); v.cw_en = 1; v.cw_data = 32'h13; v.cw_mask = 32'h1F;
    v.chk_rd = 1; v.e_rd = {32'h0, 32'h0, 32'h5555}; tv.push_back(v);
    v = nop(0, 32'hD3, 0); v.rd_en = 1; v.rd_addr = {4'd0, 4'd0, 4'd13};
    v.chk_rd = 1; v.e_rd = {32'h0, 32'h0, 32'hAAAA0000}; tv.push_back(v);
    v = nop(32'h100, 32'h10, 0); v.cw_en = 1; v.cw_data = 32'h10; v.cw_mask = 32'hFFFFFFFF;
    v.pw_en = 1; v.pw_data = 32'h100; tv.push_back(v);
    v = nop(32'h18, 32'h92, 32'h10); v.exc_req = 1; v.exc_mode = 5'b10010; v.exc_vec = 32'h18; tv.push_back(v);
    v = nop(32'h18, 32'h92, 32'h10); v.rd_en = 1; v.rd_addr = {4'd0, 4'd0, 4'd14};
    v.chk_rd = 1; v.e_rd = {32'h0, 32'h0, 32'h100}; tv.push_back(v);
    v = nop(32'h18, 32'h10, 0); v.exc_ret = 1; tv.push_back(v);
    v = nop(32'h18, 32'h10, 0); v.wr_en = 1; v.wr_addr = 3; v.wr_data = 32'h1234;
    v.rd_en = 1; v.rd_addr = {4'd0, 4'd15, 4'd3};
    v.chk_rd = 1; v.e_rd = {32'h0, 32'h18, 32'h1234}; tv.push_back(v);
    v = nop(32'h40, 32'h10, 0); v.pw_en = 1; v.pw_data = 32'h40; v.pc_inc = 1; tv.push_back(v);
    v = nop(32'hFFFFFFFC, 32'h10, 0); v.pw_en = 1; v.pw_data = 32'hFFFFFFFC; tv.push_back(v);
    v = nop(0, 32'h10, 0); v.pc_inc = 1; tv.push_back(v);
    v = nop(0, 32'h10, 0); v.wr_en = 1; v.wr_addr = 8; v.wr_data = 7; tv.push_back(v);
    v = nop(0, 32'h11, 0); v.cw_en = 1; v.cw_data = 32'h11; v.cw_mask = 32'h1F; tv.push_back(v);
    v = nop(0, 32'h11, 0); v.wr_en = 1; v.wr_addr = 8; v.wr_data = 9; tv.push_back(v);
    v = nop(0, 32'h10, 0); v.cw_en = 1; v.cw_data = 32'h10; v.cw_mask = 32'h1F; tv.push_back(v);
    v = nop(0, 32'h10, 0); v.rd_en = 1; v.rd_addr = {4'd0, 4'd0, 4'd8}; v.chk_rd = 1;
`ifdef BANKED_FIQ_EN
    v.e_rd = {32'h0, 32'h0, 32'h7};
`else
    v.e_rd = {32'h0, 32'h0, 32'h9};
`endif
    tv.push_back(v);
    v = nop(0, 32'h10, 0); v.exc_req = 1; v.exc_mode = 5'b10000; v.exc_vec = 32'h80; tv.push_back(v);
    v = nop(32'h1C, 32'hD1, 32'h10); v.exc_req = 1; v.exc_mode = 5'b10001; v.exc_vec = 32'h1C; tv.push_back(v);

    foreach (tv[i]) apply(tv[i], i);

    // Async reset landing on a cycle with a pending exception
    bus.exc_req = 1; bus.exc_mode = 5'b10010; bus.exc_vector = 32'h77;
    #2 rst = 1'b1;
    #1;
    check("async rst pc", bus.pc, RPC);
    check("async rst cpsr", bus.cpsr, 32'hD3);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    model_reset();
    check("rst-exc pc", bus.pc, RPC);
    check("rst-exc cpsr", bus.cpsr, 32'hD3);
    check("rst-exc spsr", bus.spsr, 32'h0);
    check("rst-exc rd_data", bus.rd_data, 96'h0);
    bus.cpsr_wr_en = 1; bus.cpsr_wr_data = 32'h12; bus.cpsr_wr_mask = 32'h1F;
    step();
    idle();
    check("rst-exc cpsr irq", bus.cpsr, 32'hD2);
    check("rst-exc spsr_irq", bus.spsr, 32'h0);
    bus.rd_en = 1; bus.rd_addr = {4'd0, 4'd0, 4'd14};
    step();
    idle();
    check("rst-exc r14_irq", bus.rd_data, 96'h0);

    for (int n = 0; n < 400; n++) begin
      bus.rd_en = 1'($urandom_range(0, 1));
      bus.rd_addr = 12'($urandom);
      bus.wr_en = ($urandom % 3 == 0);
      bus.wr_addr = 4'($urandom);
      bus.wr_data = $urandom;
      bus.pc_wr_en = ($urandom % 8 == 0);
      bus.pc_wr_data = $urandom;
      bus.pc_inc = 1'($urandom_range(0, 1));
      bus.cpsr_wr_en = ($urandom % 6 == 0);
      r = $urandom;
      r[4:0] = modes[$urandom % 8];
      bus.cpsr_wr_data = r;
      bus.cpsr_wr_mask = ($urandom % 2 == 0) ? 32'h1F : $urandom;
      bus.spsr_wr_en = ($urandom % 6 == 0);
      bus.exc_req = ($urandom % 10 == 0);
      bus.exc_mode = modes[$urandom % 8];
      bus.exc_vector = $urandom;
      bus.exc_ret = ($urandom % 10 == 0);
      step();
      check($sformatf("rand%0d rd_data", n), bus.rd_data, m_rd);
      check($sformatf("rand%0d pc", n), bus.pc, m_pc);
      check($sformatf("rand%0d cpsr", n), bus.cpsr, m_cpsr);
      check($sformatf("rand%0d spsr", n), bus.spsr, exp_spsr());
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
